// File: rtl/word_serializer.sv
// Free-running parallel-to-serial converter.
// Loads one WIDTH-bit word per frame and shifts it out one bit per clock.
module word_serializer #(
   parameter int WIDTH     = 10,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] I,
   output logic             O,
   output logic             frame
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_shift;
   logic [CW-1:0]    cnt;

   generate
      if (WIDTH == 1) begin : g_w1
         assign sr_shift = '0;
      end else if (MSB_FIRST) begin : g_msb
         assign sr_shift = {sr[WIDTH-2:0], 1'b0};
      end else begin : g_lsb
         assign sr_shift = {1'b0, sr[WIDTH-1:1]};
      end
   endgenerate

   // cnt==0 marks a load edge; frames run back-to-back with no idle gap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr    <= '0;
         cnt   <= '0;
         frame <= 1'b0;
      end else begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
         if (cnt == '0) begin
            sr    <= I;
            frame <= 1'b1;
         end else begin
            sr    <= sr_shift;
            frame <= 1'b0;
         end
      end
   end

   assign O = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: MSB/LSB-first at WIDTH=10 and WIDTH=1.
// Expected bit sequences are written out by hand in transmission order.
module tb_word_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] I;
   logic [0:0] I2;
   logic       o0, f0, o1, f1, o2, f2;
   int         passed = 0;
   int         total  = 0;

   always #5 clk = ~clk;

   word_serializer #(.WIDTH(10), .MSB_FIRST(1'b1)) u0 (
      .clk(clk), .reset(reset), .I(I), .O(o0), .frame(f0)
   );

   word_serializer #(.WIDTH(10), .MSB_FIRST(1'b0)) u1 (
      .clk(clk), .reset(reset), .I(I), .O(o1), .frame(f1)
   );

   word_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u2 (
      .clk(clk), .reset(reset), .I(I2), .O(o2), .frame(f2)
   );

   task automatic chk(input string tag, input logic [9:0] obs,
                      input logic [9:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // seq0/seq1 hold the expected bits of u0/u1 in transmission order,
   // first bit in position 9
   task automatic word(input string tag, input logic [9:0] w,
                       input logic [9:0] seq0, input logic [9:0] seq1);
      I = w;
      for (int n = 0; n < 10; n++) begin
         tick();
         chk({tag, "_msb_O"}, 10'(o0), 10'(seq0[9-n]));
         chk({tag, "_lsb_O"}, 10'(o1), 10'(seq1[9-n]));
         chk({tag, "_frame"}, 10'(f0), 10'(n == 0));
      end
   endtask

   initial begin
      reset = 1'b0;
      I     = 10'h3FF;
      I2    = 1'b1;
      #1;
      chk("rst_async_O", 10'(o0), 10'd0);
      chk("rst_async_frame", 10'(f0), 10'd0);

      // reset hold with clock running
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_O", 10'(o0), 10'd0);
         chk("hold_frame", 10'(f0), 10'd0);
         chk("hold_cnt", 10'(u0.cnt), 10'd0);
         chk("hold_w1_O", 10'(o2), 10'd0);
         chk("hold_w1_frame", 10'(f2), 10'd0);
      end

      I2    = 1'b0;
      reset = 1'b1;
      word("msb1", 10'b1100110011, 10'b1100110011, 10'b1100110011);

      // back-to-back frames
      word("b2b0", 10'b0010101011, 10'b0010101011, 10'b1101010100);
      word("b2b1", 10'h000, 10'h000, 10'h000);
      word("b2b2", 10'h3FF, 10'h3FF, 10'h3FF);
      word("b2b3", 10'h000, 10'h000, 10'h000);

      // input change mid-frame must be ignored
      I = 10'h3FF;
      for (int n = 0; n < 10; n++) begin
         tick();
         chk("mid_O", 10'(o0), 10'd1);
         chk("mid_lsb_O", 10'(o1), 10'd1);
         if (n == 3) I = 10'h000;
      end
      word("mid_next", 10'h000, 10'h000, 10'h000);

      // asynchronous reset between edges 4 and 5
      I = 10'h3FF;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("pre_rst_O", 10'(o0), 10'd1);
      end
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_O", 10'(o0), 10'd0);
      chk("mid_rst_lsb_O", 10'(o1), 10'd0);
      chk("mid_rst_cnt", 10'(u0.cnt), 10'd0);
      tick();
      chk("mid_rst_hold_O", 10'(o0), 10'd0);
      chk("mid_rst_hold_frame", 10'(f0), 10'd0);
      reset = 1'b1;
      I     = 10'b1100110011;
      tick();
      chk("post_rst_frame", 10'(f0), 10'd1);
      chk("post_rst_O", 10'(o0), 10'd1);
      begin
         logic [9:0] seq;
         seq = 10'b1100110011;
         for (int n = 1; n < 10; n++) begin
            tick();
            chk("post_rst_bits", 10'(o0), 10'(seq[9-n]));
            chk("post_rst_frame_lo", 10'(f0), 10'd0);
         end
      end

      // WIDTH=1: O is I one clock late, frame stuck high
      begin
         logic [4:0] v;
         logic       prev;
         v    = 5'b10110;
         prev = o2;
         for (int k = 0; k < 5; k++) begin
            I2 = v[k];
            #1;
            chk("w1_before_edge", 10'(o2), 10'(prev));
            tick();
            chk("w1_O", 10'(o2), 10'(v[k]));
            chk("w1_frame", 10'(f2), 10'd1);
            prev = v[k];
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial converter: captures a WIDTH-bit word once per frame and shifts it out one bit per clock on a single-bit line. It sits between a parallel data source (e.g. an encoder producing 10-bit symbols) and a serial output pin or downstream bit-level logic. It is free-running, with no handshake; the source must hold `I` valid at each frame boundary.

## Interface
- `WIDTH`, default 10: word length in bits, and the frame length in clocks; legal range ≥ 1.
- `MSB_FIRST`, default 1: 1 transmits `I[WIDTH-1]` first; 0 transmits `I[0]` first.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  one clock; reset is asynchronous and active-low.
- `I`  input  WIDTH  parallel word, sampled only at frame start.
- `O`  output  1  serial data, driven directly from a register.
- `frame`  output  1  high while `O` carries the first bit of a word; may be left unconnected.

## Operation
- State:
  - shift register `sr[WIDTH-1:0]`.
  - bit counter `cnt`, of width clog2(WIDTH) with a minimum of 1, counting 0..WIDTH-1.
  - `frame` register.
- Reset (`reset`=0), asynchronous, takes effect immediately, no clock needed:
  - `sr`=0, `cnt`=0, `O`=0, `frame`=0.
  - Held for as long as `reset` is low.
- Rising edge with `cnt`==0 (load):
  - `sr` <= `I`.
  - `frame` <= 1.
- Rising edge with `cnt`≠0 (shift):
  - MSB_FIRST=1: `sr` <= {`sr`[WIDTH-2:0], 1'b0}.
  - MSB_FIRST=0: `sr` <= {1'b0, `sr`[WIDTH-1:1]}.
  - `frame` <= 0.
- Counter on every edge: `cnt` <= (`cnt`==WIDTH-1) ? 0 : `cnt`+1. It wraps with no idle gap, so frames are back-to-back.
- Output `O`:
  - MSB_FIRST=1: `O` = `sr[WIDTH-1]`.
  - MSB_FIRST=0: `O` = `sr[0]`.
- Changes on `I` at any edge other than a load edge are ignored. The word loaded is the value present at the load edge.
- WIDTH=1: every edge is a load edge, `frame` stays 1, and `O` equals `I` delayed one clock.
- Vacated bit positions fill with 0. This is never visible on `O` within a frame.

## Timing
- Load edges occur at edge 0 after reset release and every WIDTH edges thereafter (edges 0, W, 2W, …).
- Latency: bit n of the word (transmission order, n = 0..WIDTH-1) appears on `O` from edge L+n until edge L+n+1, where L is the load edge.
- `frame` is high for exactly one clock per frame, aligned with bit 0 on `O`.
- Throughput: one word per WIDTH clocks, one bit per clock. Example: WIDTH=10 at a 10 ns clock gives a 100 ns frame.
- Reset mid-frame:
  - The partial word is discarded and `O` drops to 0 asynchronously.
  - After release, the first rising edge is a load edge.
- Reset release close to a clock edge is the integrator's responsibility; there is no internal synchronizer.

## Test plan
- Reset hold: `reset`=0 with clock running and `I`=10'h3FF -> `O`=0 and `frame`=0 for every cycle; `cnt` stays 0.
- MSB-first word: WIDTH=10, release reset, `I`=10'b1100110011 at edge 0 -> `O` over edges 0..9 = 1,1,0,0,1,1,0,0,1,1, with `frame`=1 only after edge 0.
- Back-to-back words: `I` changes every 10 clocks through 10'b0010101011, 10'h000, 10'h3FF, 10'h000 ->
  - `O` streams 0,0,1,0,1,0,1,0,1,1.
  - Then ten 0s, then ten 1s, then ten 0s.
  - No gaps; `frame` pulses every 10 clocks.
- Mid-frame input change: load 10'h3FF, change `I` to 10'h000 after edge 3 -> `O` remains 1 through edge 9; the next frame outputs ten 0s.
- Asynchronous reset mid-frame: assert `reset`=0 between edges 4 and 5 of a frame -> `O`=0 immediately, without waiting for a clock edge. After release, the first edge loads the current `I` and `frame`=1.
- LSB-first and WIDTH=1: with MSB_FIRST=0 and WIDTH=10, `I`=10'b0010101011 -> `O` = 1,1,0,1,0,1,0,1,0,0. With WIDTH=1 -> `O` follows `I` one clock late and `frame` stays 1.
